// File: rtl/sdc16_pkg.sv
// Shared types and constants for the sdc16 down-counter/timer.
package sdc16_pkg;

    localparam int SDC16_WIDTH = 16;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        EXPIRE = 2'd2
    } state_t;

endpackage

// File: rtl/dcnt_reg.sv
// Count register for sdc16_timer: synchronous reset, load, and decrement that stops at zero.
module dcnt_reg
    import sdc16_pkg::*;
#(
    parameter int WIDTH = SDC16_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             ld_i,
    input  logic [WIDTH-1:0] ld_val_i,
    input  logic             dec_i,
    output logic [WIDTH-1:0] q_o
);

    logic [WIDTH-1:0] q_q;

    // Load outranks decrement; the zero guard keeps the count from wrapping.
    always_ff @(posedge clk) begin
        if (reset) begin
            q_q <= '0;
        end else if (ld_i) begin
            q_q <= ld_val_i;
        end else if (dec_i && (q_q != '0)) begin
            q_q <= q_q - WIDTH'(1);
        end
    end

    assign q_o = q_q;

endmodule

// File: rtl/sdc16_timer.sv
// 16-bit programmable down-counter/timer: load a count, decrement on en, pulse tc at zero.
// Define SDC16_AUTO_RELOAD_EN to restart from the last loaded value after each expiry.
module sdc16_timer
    import sdc16_pkg::*;
#(
    parameter int WIDTH = SDC16_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             en,
    output logic [WIDTH-1:0] q,
    output logic             busy,
    output logic             tc
);

    state_t           state_q, state_d;
    logic             busy_q, tc_q;
    logic             cnt_ld, cnt_dec;
    logic [WIDTH-1:0] cnt_val;

`ifdef SDC16_AUTO_RELOAD_EN
    // Only the reload path reads this, so it exists only when reload is built in.
    logic [WIDTH-1:0] reload_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            reload_q <= '0;
        end else if (load) begin
            reload_q <= load_val;
        end
    end
`endif

    always_comb begin
        state_d = state_q;
        cnt_ld  = 1'b0;
        cnt_dec = 1'b0;
        cnt_val = load_val;
        if (load) begin
            cnt_ld  = 1'b1;
            state_d = (load_val != '0) ? RUN : EXPIRE;
        end else begin
            case (state_q)
                RUN: begin
                    if (en) begin
                        cnt_dec = 1'b1;
                        if (q <= WIDTH'(1)) begin
                            state_d = EXPIRE;
                        end
                    end
                end
                EXPIRE: begin
`ifdef SDC16_AUTO_RELOAD_EN
                    cnt_ld  = 1'b1;
                    cnt_val = reload_q;
                    state_d = (reload_q != '0) ? RUN : EXPIRE;
`else
                    // q is already zero here; clearing it again keeps IDLE exact.
                    cnt_ld  = 1'b1;
                    cnt_val = '0;
                    state_d = IDLE;
`endif
                end
                default: state_d = state_q;
            endcase
        end
    end

    // Outputs are registered from the next state so they change only with state_q.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
            tc_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            busy_q  <= (state_d != IDLE);
            tc_q    <= (state_d == EXPIRE);
        end
    end

    dcnt_reg #(
        .WIDTH(WIDTH)
    ) u_cnt (
        .clk      (clk),
        .reset    (reset),
        .ld_i     (cnt_ld),
        .ld_val_i (cnt_val),
        .dec_i    (cnt_dec),
        .q_o      (q)
    );

    assign busy = busy_q;
    assign tc   = tc_q;

endmodule

// File: tb/tb_sdc16_timer.sv
// Testbench for sdc16_timer: directed vector table, multi-cycle corner sequences, random vs model.
module tb_sdc16_timer;

    logic        clk = 1'b0;
    logic        reset, load, en;
    logic [15:0] load_val;
    logic [15:0] q;
    logic        busy, tc;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    sdc16_timer #(.WIDTH(16)) dut (
        .clk      (clk),
        .reset    (reset),
        .load     (load),
        .load_val (load_val),
        .en       (en),
        .q        (q),
        .busy     (busy),
        .tc       (tc)
    );

    typedef struct {
        logic        ld;
        logic [15:0] lv;
        logic        e;
        logic [15:0] xq;
        logic        xb;
        logic        xt;
    } vec_t;

    vec_t tv[$];

    // Reference model: remaining count plus "counting" / "expired" flags.
    int unsigned m_q, m_reload;
    bit          m_counting, m_expired;

    task automatic model_step(input bit r, input bit l, input int unsigned lv, input bit e);
        if (r) begin
            m_q = 0; m_reload = 0; m_counting = 0; m_expired = 0;
        end else if (l) begin
            m_q = lv; m_reload = lv;
            m_counting = (lv != 0);
            m_expired  = (lv == 0);
        end else if (m_expired) begin
`ifdef SDC16_AUTO_RELOAD_EN
            m_q = m_reload;
            m_counting = (m_reload != 0);
            m_expired  = (m_reload == 0);
`else
            m_q = 0; m_counting = 0; m_expired = 0;
`endif
        end else if (m_counting && e) begin
            m_q = m_q - 1;
            if (m_q == 0) begin
                m_counting = 0;
                m_expired  = 1;
            end
        end
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic tick(input logic l, input logic [15:0] lv, input logic e, input logic r);
        reset = r; load = l; load_val = lv; en = e;
        @(posedge clk);
        #1;
    endtask

    task automatic chk_out(input string name, input logic [15:0] xq, input logic xb, input logic xt);
        chk({name, "_q"}, q, xq);
        chk({name, "_busy"}, busy, xb);
        chk({name, "_tc"}, tc, xt);
    endtask

    initial begin
        int edges;

        reset = 1'b1; load = 1'b0; load_val = '0; en = 1'b0;
        tick(0, 0, 0, 1);
        tick(0, 0, 0, 1);
        chk_out("reset", 16'h0, 0, 0);

        // Directed table: basic count, gated count, load priority, zero load, load in EXPIRE.
        tv.push_back('{1, 5, 1, 5, 1, 0});
        tv.push_back('{0, 0, 1, 4, 1, 0});
        tv.push_back('{0, 0, 1, 3, 1, 0});
        tv.push_back('{0, 0, 1, 2, 1, 0});
        tv.push_back('{0, 0, 1, 1, 1, 0});
        tv.push_back('{0, 0, 1, 0, 1, 1});
`ifndef SDC16_AUTO_RELOAD_EN
        tv.push_back('{0, 0, 1, 0, 0, 0});
        tv.push_back('{0, 0, 1, 0, 0, 0});
`endif
        tv.push_back('{1, 3, 1, 3, 1, 0});
        tv.push_back('{0, 0, 1, 2, 1, 0});
        tv.push_back('{0, 0, 0, 2, 1, 0});
        tv.push_back('{0, 0, 0, 2, 1, 0});
        tv.push_back('{0, 0, 1, 1, 1, 0});
        tv.push_back('{0, 0, 1, 0, 1, 1});
        tv.push_back('{1, 5, 1, 5, 1, 0});
        tv.push_back('{0, 0, 1, 4, 1, 0});
        tv.push_back('{0, 0, 1, 3, 1, 0});
        tv.push_back('{0, 0, 1, 2, 1, 0});
        tv.push_back('{1, 7, 1, 7, 1, 0});
        tv.push_back('{0, 0, 1, 6, 1, 0});
        tv.push_back('{1, 0, 1, 0, 1, 1});
        tv.push_back('{1, 4, 1, 4, 1, 0});
        tv.push_back('{0, 0, 0, 4, 1, 0});
        tv.push_back('{1, 0, 0, 0, 1, 1});
`ifdef SDC16_AUTO_RELOAD_EN
        tv.push_back('{0, 0, 0, 0, 1, 1});
        tv.push_back('{0, 0, 1, 0, 1, 1});
`else
        tv.push_back('{0, 0, 0, 0, 0, 0});
        tv.push_back('{0, 0, 1, 0, 0, 0});
`endif
        foreach (tv[i]) begin
            tick(tv[i].ld, tv[i].lv, tv[i].e, 0);
            chk_out($sformatf("vec%0d", i), tv[i].xq, tv[i].xb, tv[i].xt);
        end

        // Reset mid-RUN, held two cycles, also overriding a load.
        tick(1, 16'h0123, 1, 0);
        chk_out("run_0123", 16'h0123, 1, 0);
        tick(0, 0, 1, 1);
        chk_out("rst_mid1", 16'h0, 0, 0);
        tick(1, 16'h9, 1, 1);
        chk_out("rst_mid2", 16'h0, 0, 0);

        // Reset while in EXPIRE.
        tick(1, 0, 0, 0);
        chk_out("exp_before_rst", 16'h0, 1, 1);
        tick(0, 0, 0, 1);
        chk_out("rst_in_exp", 16'h0, 0, 0);

        // Maximum load: tc after exactly 65535 enabled edges.
        tick(1, 16'hFFFF, 1, 0);
        chk_out("max_load", 16'hFFFF, 1, 0);
        edges = 0;
        for (int n = 1; n <= 70000; n++) begin
            tick(0, 0, 1, 0);
            if (tc) begin
                edges = n;
                break;
            end
        end
        chk("max_latency", edges, 65535);
        chk("max_final_q", q, 16'h0);

`ifdef SDC16_AUTO_RELOAD_EN
        // Periodic mode: q cycles 3,2,1,0 with tc on the zero cycle, busy never drops.
        tick(1, 3, 1, 0);
        for (int k = 1; k <= 20; k++) begin
            tick(0, 0, 1, 0);
            chk_out($sformatf("auto%0d", k), 16'(3 - (k % 4)), 1, (k % 4) == 3);
        end
`endif

        // Randomized traffic against the reference model.
        tick(0, 0, 0, 1);
        model_step(1, 0, 0, 0);
        for (int c = 0; c < 3000; c++) begin
            logic        r, l, e;
            logic [15:0] lv;
            r  = ($urandom_range(0, 99) == 0);
            l  = ($urandom_range(0, 7) == 0);
            e  = ($urandom_range(0, 3) != 0);
            lv = ($urandom_range(0, 9) == 0) ? 16'($urandom) : 16'($urandom_range(0, 6));
            tick(l, lv, e, r);
            model_step(r, l, lv, e);
            chk_out($sformatf("rnd%0d", c), 16'(m_q), m_counting || m_expired, m_expired);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
